operand_mux_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered 2:1 operand mux between two requesters feeding the matrix-multiplication MAC datapath. The block grants one source at a time for bursts of up to `BURST` beats and drives the mux `select`. It registers the chosen operand onto a single valid/ready output stream. It sits between the row/column operand fetch units and the multiply-accumulate stage.

---
 rtl/operand_mux_arbiter_pkg.sv | 15 +
 rtl/operand_mux_arbiter_pick.sv | 24 ++
 rtl/operand_mux_arbiter.sv | 138 +++++++++++++
 tb/tb_operand_mux_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_mux_arbiter_pkg.sv
// Shared types and constants for the operand mux arbiter.
package operand_mux_arbiter_pkg;

    // Grant state of the shared operand mux.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE1 = 2'd1,
        SERVE2 = 2'd2
    } state_t;

    // Mux select encoding; also used as the source id (1 = in1, 0 = in2).
    localparam logic SEL_IN1 = 1'b1;
    localparam logic SEL_IN2 = 1'b0;

endpackage

// File: rtl/operand_mux_arbiter_pick.sv
// Two-requester round-robin pick: when both request, the source that was
// not served last wins; a lone requester always wins.
import operand_mux_arbiter_pkg::*;

module rr_pick2 (
    input  logic v1,
    input  logic v2,
    input  logic last,
    output logic grant_valid,
    output logic grant_src
);

    // Combinational pick; grant_src uses the mux select encoding.
    always_comb begin
        grant_valid = v1 | v2;
        grant_src   = SEL_IN2;
        if (v1 && v2) begin
            grant_src = (last == SEL_IN1) ? SEL_IN2 : SEL_IN1;
        end else if (v1) begin
            grant_src = SEL_IN1;
        end
    end

endmodule

// File: rtl/operand_mux_arbiter.sv
// Round-robin arbiter sharing one registered 2:1 operand mux between two
// requesters, with burst-limited grants and a single valid/ready output.
//
// Handshake: every stream (in1, in2, out) transfers a beat on a rising edge
// where valid and ready are both high. Valid never depends on ready. The
// input readies are decoded from registered state and out_ready only, so
// there is no combinational path from inX_valid to inX_ready.
import operand_mux_arbiter_pkg::*;

module operand_mux_arbiter #(
    parameter int WIDTH = 4,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    input  logic             in2_valid,
    input  logic [WIDTH-1:0] in2_data,
    output logic             in2_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             select,
    output logic             out_src,
    output logic             busy,
    output state_t           dbg_state
);

    localparam int CNT_W = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_src_q;
    logic             select_q;

    logic             slot_free;
    logic             serving;
    logic             cur_src;
    logic             cur_valid;
    logic [WIDTH-1:0] cur_data;
    logic             beat;
    logic             leave;
    logic             pick_last;
    logic             grant_valid;
    logic             grant_src;

    // Output slot can take a new operand when empty or being drained now.
    assign slot_free = !out_valid_q || out_ready;
    assign in1_ready = (state_q == SERVE1) && slot_free;
    assign in2_ready = (state_q == SERVE2) && slot_free;

    // Decode the granted source, beat and grant-release conditions.
    always_comb begin
        serving   = (state_q == SERVE1) || (state_q == SERVE2);
        cur_src   = (state_q == SERVE1) ? SEL_IN1 : SEL_IN2;
        cur_valid = (state_q == SERVE1) ? in1_valid : in2_valid;
        cur_data  = (state_q == SERVE1) ? in1_data : in2_data;
        beat      = (in1_valid && in1_ready) || (in2_valid && in2_ready);
        // Release on the beat that completes the burst, or when the granted
        // requester has nothing to send this cycle.
        leave     = serving && ((beat && (cnt_q == LAST_BEAT)) || !cur_valid);
        // While serving, the source being released counts as "last" so the
        // exit pick already sees the updated pointer.
        pick_last = serving ? cur_src : last_q;
    end

    rr_pick2 u_pick (
        .v1          (in1_valid),
        .v2          (in2_valid),
        .last        (pick_last),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    // Grant FSM, beat counter, round-robin pointer and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= SEL_IN2;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            select_q    <= SEL_IN2;
        end else begin
            if (beat) begin
                out_valid_q <= 1'b1;
                out_data_q  <= cur_data;
                out_src_q   <= cur_src;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        state_q  <= (grant_src == SEL_IN1) ? SERVE1 : SERVE2;
                        select_q <= grant_src;
                        cnt_q    <= '0;
                    end
                end
                SERVE1, SERVE2: begin
                    if (leave) begin
                        last_q <= cur_src;
                        cnt_q  <= '0;
                        if (grant_valid) begin
                            state_q  <= (grant_src == SEL_IN1) ? SERVE1 : SERVE2;
                            select_q <= grant_src;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (beat) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign select    = select_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_operand_mux_arbiter.sv
// Bench for operand_mux_arbiter: BURST=4 instance for the main scenarios,
// BURST=1 instance for strict alternation and back-to-back re-grants.
import operand_mux_arbiter_pkg::*;

module tb_operand_mux_arbiter;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // BURST=4 instance
    logic         in1_valid, in2_valid, out_ready;
    logic [W-1:0] in1_data, in2_data;
    logic         in1_ready, in2_ready, out_valid, select, out_src, busy;
    logic [W-1:0] out_data;
    state_t       dbg_state;

    // BURST=1 instance
    logic         b_in1_valid, b_in2_valid, b_out_ready;
    logic [W-1:0] b_in1_data, b_in2_data;
    logic         b_in1_ready, b_in2_ready, b_out_valid, b_select, b_out_src, b_busy;
    logic [W-1:0] b_out_data;
    state_t       b_dbg_state;

    operand_mux_arbiter #(.WIDTH(W), .BURST(4)) dut (
        .clk(clk), .rst(rst),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .in2_valid(in2_valid), .in2_data(in2_data), .in2_ready(in2_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .select(select), .out_src(out_src), .busy(busy), .dbg_state(dbg_state)
    );

    operand_mux_arbiter #(.WIDTH(W), .BURST(1)) dut1 (
        .clk(clk), .rst(rst),
        .in1_valid(b_in1_valid), .in1_data(b_in1_data), .in1_ready(b_in1_ready),
        .in2_valid(b_in2_valid), .in2_data(b_in2_data), .in2_ready(b_in2_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .select(b_select), .out_src(b_out_src), .busy(b_busy), .dbg_state(b_dbg_state)
    );

    // Scoreboard: expected {src, data} per output transfer.
    logic [W:0] exp_q[$];
    logic [W:0] exp1_q[$];
    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for BURST=4 output stream.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL out4_unexpected: got 0x%0h expected none at %0t",
                         {out_src, out_data}, $time);
            end else begin
                check("out4", int'({out_src, out_data}), int'(exp_q.pop_front()));
            end
        end
    end

    // Monitor for BURST=1 output stream.
    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (exp1_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL out1_unexpected: got 0x%0h expected none at %0t",
                         {b_out_src, b_out_data}, $time);
            end else begin
                check("out1", int'({b_out_src, b_out_data}), int'(exp1_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat on in1 and hold it until accepted.
    task automatic push_beat1(input logic [W-1:0] d);
        logic acc;
        acc = 1'b0;
        in1_valid = 1'b1;
        in1_data  = d;
        exp_q.push_back({SEL_IN1, d});
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = in1_ready;
            tick();
        end
        if (!acc) begin
            vectors++;
            errors++;
            $display("FAIL push1_timeout: got no ready expected ready for 0x%0h", d);
        end
    endtask

    // Offer one beat on in2 and hold it until accepted.
    task automatic push_beat2(input logic [W-1:0] d);
        logic acc;
        acc = 1'b0;
        in2_valid = 1'b1;
        in2_data  = d;
        exp_q.push_back({SEL_IN2, d});
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = in2_ready;
            tick();
        end
        if (!acc) begin
            vectors++;
            errors++;
            $display("FAIL push2_timeout: got no ready expected ready for 0x%0h", d);
        end
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        int n;
        rst = 1'b1;
        in1_valid = 0; in2_valid = 0; in1_data = 0; in2_data = 0; out_ready = 1;
        b_in1_valid = 0; b_in2_valid = 0; b_in1_data = 0; b_in2_data = 0; b_out_ready = 1;
        repeat (3) tick();

        // Reset values
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_select", int'(select), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_readies", int'({in1_ready, in2_ready}), 0);
        rst = 1'b0;
        tick();

        // Single stream on in1: 3, 5, 7
        in1_valid = 1; in1_data = 4'h3;
        @(negedge clk);
        check("s_ready_before_grant", int'(in1_ready), 0);
        tick();
        check("s_ready_after_grant", int'(in1_ready), 1);
        check("s_select", int'(select), 1);
        check("s_in2_ready", int'(in2_ready), 0);
        check("s_state", int'(dbg_state), int'(SERVE1));
        push_beat1(4'h3);
        push_beat1(4'h5);
        push_beat1(4'h7);
        in1_valid = 0;
        repeat (3) tick();
        check("s_idle_busy", int'(busy), 0);
        check("s_idle_out_valid", int'(out_valid), 0);

        // Contention, last = in1 so in2 wins first: 4x5, 4xA, 4x5
        in1_data = 4'hA; in2_data = 4'h5;
        in1_valid = 1; in2_valid = 1;
        for (int i = 0; i < 12; i++)
            exp_q.push_back(((i / 4) % 2 == 0) ? {SEL_IN2, 4'h5} : {SEL_IN1, 4'hA});
        tick();
        check("c_first_grant", int'(dbg_state), int'(SERVE2));
        n = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) n++;
        end
        in1_valid = 0; in2_valid = 0;
        check("c_no_bubble", n, 12);
        repeat (3) tick();

        // Backpressure during an in1 stream of 1..6
        fork
            begin
                for (int v = 1; v <= 6; v++) push_beat1(4'(v));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 0;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_out_valid", int'(out_valid), 1);
                    check("bp_out_data", int'(out_data), 2);
                    check("bp_readies", int'({in1_ready, in2_ready}), 0);
                    check("bp_state", int'(dbg_state), int'(SERVE1));
                    tick();
                end
                out_ready = 1;
            end
        join
        in1_valid = 0;
        repeat (3) tick();

        // Yield: in1 drops valid after 2 beats while in2 waits
        push_beat1(4'hB);
        in2_valid = 1; in2_data = 4'h9;
        push_beat1(4'hC);
        in1_valid = 0;
        tick();
        check("y_select", int'(select), 0);
        check("y_state", int'(dbg_state), int'(SERVE2));
        check("y_readies", int'({in1_ready, in2_ready}), 1);
        push_beat2(4'h9);
        in1_valid = 1; in1_data = 4'hD;
        push_beat2(4'h8);
        in2_valid = 0;
        push_beat1(4'hD);
        in1_valid = 0;
        repeat (3) tick();

        // Reset mid-stream, then in1 wins first after release
        in1_data = 4'h6; in2_data = 4'h3;
        in1_valid = 1; in2_valid = 1;
        tick();
        tick();
        check("r_pre_out", int'({out_valid, out_src, out_data}), int'({1'b1, 1'b0, 4'h3}));
        #2;
        rst = 1'b1;
        #1;
        check("r_async_out_valid", int'(out_valid), 0);
        check("r_async_out_data", int'(out_data), 0);
        check("r_async_busy", int'(busy), 0);
        check("r_async_misc", int'({select, out_src, in1_ready, in2_ready}), 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("r_first_grant", int'(dbg_state), int'(SERVE1));
        check("r_first_select", int'(select), 1);
        check("r_first_readies", int'({in1_ready, in2_ready}), 2);
        in1_valid = 0; in2_valid = 0;
        repeat (3) tick();

        // BURST=1: strict alternation, then in1 alone re-granted each beat
        b_in1_data = 4'h1; b_in2_data = 4'h2;
        b_in1_valid = 1; b_in2_valid = 1;
        for (int i = 0; i < 6; i++)
            exp1_q.push_back((i % 2 == 0) ? {SEL_IN1, 4'h1} : {SEL_IN2, 4'h2});
        for (int i = 0; i < 4; i++) exp1_q.push_back({SEL_IN1, 4'h1});
        tick();
        check("b1_first_grant", int'(b_dbg_state), int'(SERVE1));
        n = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (b_out_valid) n++;
        end
        b_in2_valid = 0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (b_out_valid) n++;
        end
        b_in1_valid = 0;
        check("b1_full_rate", n, 10);
        repeat (4) tick();

        check("sb4_drained", exp_q.size(), 0);
        check("sb1_drained", exp1_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
